// File: rtl/sfp_link_pkg.sv
// ----------------------------------------------------------------------------
// sfp_link_pkg: shared state encodings and sizing helpers for the SFP link
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sfp_link_pkg;

   typedef enum logic [1:0] {
      T_IDLE = 2'd0,
      T_SEND = 2'd1
   } tx_state_t;

   typedef enum logic [1:0] {
      R_IDLE    = 2'd0,
      R_COLLECT = 2'd1,
      R_DROP    = 2'd2
   } rx_state_t;

   function automatic int beats(input int data_bit, input int axis_bit);
      return data_bit / axis_bit;
   endfunction

   function automatic int beat_cnt_width(input int data_bit, input int axis_bit);
      return $clog2(beats(data_bit, axis_bit));
   endfunction

endpackage

`default_nettype wire

// File: rtl/sfp_rx_assembler.sv
// ----------------------------------------------------------------------------
// sfp_rx_assembler: rebuilds words from AXI4-Stream beats, checks framing
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sfp_rx_assembler
   import sfp_link_pkg::*;
#(
   parameter int C_AXIS_TDATA_WIDTH = 32,
   parameter int C_DATA_BIT         = 64,
   parameter int C_RX_TIMEOUT       = 1024
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [C_AXIS_TDATA_WIDTH-1:0] tdata,
   input  logic                          tvalid,
   input  logic                          tlast,
   output logic                          tready,
   output logic [C_DATA_BIT-1:0]         word,
   output logic                          end_flag,
   output logic                          err,
   output rx_state_t                     state
);

   localparam int N  = beats(C_DATA_BIT, C_AXIS_TDATA_WIDTH);
   localparam int CW = beat_cnt_width(C_DATA_BIT, C_AXIS_TDATA_WIDTH);
   localparam int TW = $clog2(C_RX_TIMEOUT + 1);
   localparam logic [CW-1:0] LAST_BEAT  = CW'(N - 1);
   localparam logic [TW-1:0] IDLE_LIMIT = TW'(C_RX_TIMEOUT - 1);

   rx_state_t               state_q;
   rx_state_t               state_d;
   logic [CW-1:0]           beat_cnt;
   logic [TW-1:0]           idle_cnt;
   logic [C_DATA_BIT-1:0]   asm_reg;
   logic [C_DATA_BIT-1:0]   asm_next;
   logic                    beat;
   logic                    good_d;
   logic                    err_d;

   assign tready   = ~rst;
   assign beat     = tvalid & tready;
   assign asm_next = {asm_reg[C_DATA_BIT-C_AXIS_TDATA_WIDTH-1:0], tdata};
   assign state    = state_q;

   always_ff @(posedge clk) begin
      if (rst) state_q <= R_IDLE;
      else     state_q <= state_d;
   end

   // beat_cnt is always 0 in R_IDLE, so one branch serves both idle and collect
   always_comb begin
      state_d = state_q;
      good_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         R_IDLE, R_COLLECT: begin
            if (beat) begin
               if (tlast) begin
                  state_d = R_IDLE;
                  if (beat_cnt == LAST_BEAT) good_d = 1'b1;
                  else                       err_d  = 1'b1;
               end else if (beat_cnt == LAST_BEAT) begin
                  state_d = R_DROP;
                  err_d   = 1'b1;
               end else begin
                  state_d = R_COLLECT;
               end
            end else if (state_q == R_COLLECT && idle_cnt == IDLE_LIMIT) begin
               state_d = R_IDLE;
               err_d   = 1'b1;
            end
         end
         R_DROP: begin
            if (beat && tlast) state_d = R_IDLE;
         end
         default: state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt <= '0;
         idle_cnt <= '0;
         asm_reg  <= '0;
         word     <= '0;
         end_flag <= 1'b0;
         err      <= 1'b0;
      end else begin
         end_flag <= good_d;
         err      <= err_d;
         if (good_d) word <= asm_next;
         if (beat && state_q != R_DROP) asm_reg <= asm_next;
         if (state_d == R_COLLECT && beat) beat_cnt <= beat_cnt + CW'(1);
         else if (state_d != R_COLLECT)    beat_cnt <= '0;
         if (state_q == R_COLLECT && state_d == R_COLLECT && !beat)
            idle_cnt <= idle_cnt + TW'(1);
         else
            idle_cnt <= '0;
      end
   end

endmodule

`default_nettype wire

// File: rtl/sfp_stream_link.sv
// ----------------------------------------------------------------------------
// sfp_stream_link: word handshake <-> AXI4-Stream bridge toward the SFP core
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sfp_stream_link
   import sfp_link_pkg::*;
#(
   parameter int C_AXIS_TDATA_WIDTH = 32,
   parameter int C_DATA_BIT         = 64,
   parameter int C_RX_TIMEOUT       = 1024
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_sfp_start_flag,
   input  logic [C_DATA_BIT-1:0]         i_tx_stream_data,
   output logic                          o_tx_busy,
   output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                          m_axis_tvalid,
   output logic                          m_axis_tlast,
   input  logic                          m_axis_tready,
   input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic                          s_axis_tvalid,
   input  logic                          s_axis_tlast,
   output logic                          s_axis_tready,
   output logic [C_DATA_BIT-1:0]         o_rx_stream_data,
   output logic                          o_sfp_end_flag,
   output logic                          o_rx_err,
   output logic [3:0]                    o_link_state
);

   localparam int N  = beats(C_DATA_BIT, C_AXIS_TDATA_WIDTH);
   localparam int CW = beat_cnt_width(C_DATA_BIT, C_AXIS_TDATA_WIDTH);
   localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);

   tx_state_t             tx_q;
   tx_state_t             tx_d;
   logic [C_DATA_BIT-1:0] tx_shift;
   logic [CW-1:0]         tx_cnt;
   logic                  tx_send;
   logic                  tx_hs;
   logic                  tx_last;
   rx_state_t             rx_state;

   assign tx_send = (tx_q == T_SEND);
   assign tx_hs   = tx_send & m_axis_tready;
   assign tx_last = tx_send && (tx_cnt == LAST_BEAT);

   assign o_tx_busy     = tx_send;
   assign m_axis_tvalid = tx_send;
   assign m_axis_tlast  = tx_last;
   assign m_axis_tdata  = tx_shift[C_DATA_BIT-1 -: C_AXIS_TDATA_WIDTH];
   assign o_link_state  = {tx_q, rx_state};

   always_ff @(posedge i_clk) begin
      if (i_rst) tx_q <= T_IDLE;
      else       tx_q <= tx_d;
   end

   always_comb begin
      tx_d = tx_q;
      case (tx_q)
         T_IDLE:  if (i_sfp_start_flag) tx_d = T_SEND;
         T_SEND:  if (tx_hs && tx_last) tx_d = T_IDLE;
         default: tx_d = T_IDLE;
      endcase
   end

   // Start pulses are only looked at in T_IDLE, so a pulse mid-frame is dropped
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         tx_shift <= '0;
         tx_cnt   <= '0;
      end else if (tx_q == T_IDLE && i_sfp_start_flag) begin
         tx_shift <= i_tx_stream_data;
         tx_cnt   <= '0;
      end else if (tx_hs) begin
         tx_shift <= tx_shift << C_AXIS_TDATA_WIDTH;
         tx_cnt   <= tx_last ? '0 : tx_cnt + CW'(1);
      end
   end

   sfp_rx_assembler #(
      .C_AXIS_TDATA_WIDTH (C_AXIS_TDATA_WIDTH),
      .C_DATA_BIT         (C_DATA_BIT),
      .C_RX_TIMEOUT       (C_RX_TIMEOUT)
   ) u_rx (
      .clk      (i_clk),
      .rst      (i_rst),
      .tdata    (s_axis_tdata),
      .tvalid   (s_axis_tvalid),
      .tlast    (s_axis_tlast),
      .tready   (s_axis_tready),
      .word     (o_rx_stream_data),
      .end_flag (o_sfp_end_flag),
      .err      (o_rx_err),
      .state    (rx_state)
   );

endmodule

`default_nettype wire

// File: tb/tb_sfp_stream_link.sv
// ----------------------------------------------------------------------------
// tb_sfp_stream_link: scoreboard bench for the SFP stream link
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sfp_stream_link;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [63:0] tx_word;
   logic        o_tx_busy;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tlast;
   logic        m_axis_tready;
   logic [31:0] s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tlast;
   logic        s_axis_tready;
   logic [63:0] o_rx_stream_data;
   logic        o_sfp_end_flag;
   logic        o_rx_err;
   logic [3:0]  o_link_state;

   logic        loop;
   logic [31:0] drv_tdata;
   logic        drv_tvalid;
   logic        drv_tlast;
   logic        drv_tready;

   assign s_axis_tdata  = loop ? m_axis_tdata  : drv_tdata;
   assign s_axis_tvalid = loop ? m_axis_tvalid : drv_tvalid;
   assign s_axis_tlast  = loop ? m_axis_tlast  : drv_tlast;
   assign m_axis_tready = loop ? s_axis_tready : drv_tready;

   always #5 clk = ~clk;

   sfp_stream_link #(
      .C_AXIS_TDATA_WIDTH (32),
      .C_DATA_BIT         (64),
      .C_RX_TIMEOUT       (1024)
   ) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_sfp_start_flag (start),
      .i_tx_stream_data (tx_word),
      .o_tx_busy        (o_tx_busy),
      .m_axis_tdata     (m_axis_tdata),
      .m_axis_tvalid    (m_axis_tvalid),
      .m_axis_tlast     (m_axis_tlast),
      .m_axis_tready    (m_axis_tready),
      .s_axis_tdata     (s_axis_tdata),
      .s_axis_tvalid    (s_axis_tvalid),
      .s_axis_tlast     (s_axis_tlast),
      .s_axis_tready    (s_axis_tready),
      .o_rx_stream_data (o_rx_stream_data),
      .o_sfp_end_flag   (o_sfp_end_flag),
      .o_rx_err         (o_rx_err),
      .o_link_state     (o_link_state)
   );

   typedef struct {
      logic [31:0] data;
      logic        last;
   } tx_exp_t;

   tx_exp_t     tx_q[$];
   logic [63:0] rx_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          end_cnt  = 0;
   int          err_cnt  = 0;
   int          ends0;
   int          errs0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops expectations whenever the DUT presents a beat or a word
   always @(negedge clk) begin
      tx_exp_t e;
      logic [63:0] w;
      if (m_axis_tvalid && m_axis_tready) begin
         if (tx_q.size() == 0) chk("tx_unexpected_beat", {32'h0, m_axis_tdata}, 64'hx);
         else begin
            e = tx_q.pop_front();
            chk("tx_beat_data", {32'h0, m_axis_tdata}, {32'h0, e.data});
            chk("tx_beat_last", {63'h0, m_axis_tlast}, {63'h0, e.last});
         end
      end
      if (o_sfp_end_flag) begin
         end_cnt++;
         if (rx_q.size() == 0) chk("rx_unexpected_word", o_rx_stream_data, 64'hx);
         else begin
            w = rx_q.pop_front();
            chk("rx_word", o_rx_stream_data, w);
         end
      end
      if (o_rx_err) err_cnt++;
   end

   task automatic send_start(input logic [63:0] d);
      @(posedge clk); #1;
      start   = 1'b1;
      tx_word = d;
      @(posedge clk); #1;
      start   = 1'b0;
   endtask

   task automatic rx_beat(input logic [31:0] d, input logic l);
      @(posedge clk); #1;
      drv_tvalid = 1'b1;
      drv_tdata  = d;
      drv_tlast  = l;
   endtask

   task automatic rx_idle();
      @(posedge clk); #1;
      drv_tvalid = 1'b0;
      drv_tlast  = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; start = 1'b0; tx_word = '0; loop = 1'b0;
      drv_tdata = '0; drv_tvalid = 1'b0; drv_tlast = 1'b0; drv_tready = 1'b1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_s_tready", {63'h0, s_axis_tready}, 64'h0);
      chk("reset_m_tvalid", {63'h0, m_axis_tvalid}, 64'h0);
      chk("reset_link_state", {60'h0, o_link_state}, 64'h0);
      chk("reset_rx_data", o_rx_stream_data, 64'h0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("s_tready_after_reset", {63'h0, s_axis_tready}, 64'h1);
      chk("idle_busy", {63'h0, o_tx_busy}, 64'h0);
      chk("idle_flags", {62'h0, o_sfp_end_flag, o_rx_err}, 64'h0);

      // TX single frame
      tx_q.push_back('{32'h11223344, 1'b0});
      tx_q.push_back('{32'h55667788, 1'b1});
      send_start(64'h1122334455667788);
      @(negedge clk);
      chk("tx_t1_valid_busy", {62'h0, m_axis_tvalid, o_tx_busy}, 64'h3);
      chk("tx_t1_tlast", {63'h0, m_axis_tlast}, 64'h0);
      @(negedge clk);
      chk("tx_t2_tlast", {63'h0, m_axis_tlast}, 64'h1);
      @(negedge clk);
      chk("tx_t3_idle", {62'h0, m_axis_tvalid, o_tx_busy}, 64'h0);

      // TX backpressure with a stray start pulse
      drv_tready = 1'b0;
      tx_q.push_back('{32'hA1A2A3A4, 1'b0});
      tx_q.push_back('{32'hB1B2B3B4, 1'b1});
      send_start(64'hA1A2A3A4B1B2B3B4);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_tvalid", {63'h0, m_axis_tvalid}, 64'h1);
         chk("bp_tdata", {32'h0, m_axis_tdata}, 64'hA1A2A3A4);
         chk("bp_tlast", {63'h0, m_axis_tlast}, 64'h0);
         if (i == 1) begin start = 1'b1; tx_word = 64'hFFFF0000FFFF0000; end
         if (i == 2) start = 1'b0;
      end
      @(posedge clk); #1 drv_tready = 1'b1;
      repeat (4) @(negedge clk);
      chk("bp_done_idle", {62'h0, m_axis_tvalid, o_tx_busy}, 64'h0);

      // RX good frames, back to back
      ends0 = end_cnt;
      rx_q.push_back(64'hDEADBEEF01020304);
      rx_q.push_back(64'h0A0B0C0D0E0F1011);
      rx_beat(32'hDEADBEEF, 1'b0);
      rx_beat(32'h01020304, 1'b1);
      rx_beat(32'h0A0B0C0D, 1'b0);
      rx_beat(32'h0E0F1011, 1'b1);
      rx_idle();
      repeat (3) @(negedge clk);
      chk("rx_good_count", 64'(end_cnt - ends0), 64'd2);

      // RX early tlast, then a good frame
      ends0 = end_cnt; errs0 = err_cnt;
      rx_beat(32'h99999999, 1'b1);
      rx_idle();
      repeat (3) @(negedge clk);
      chk("early_err_count", 64'(err_cnt - errs0), 64'd1);
      chk("early_no_end", 64'(end_cnt - ends0), 64'd0);
      chk("early_data_held", o_rx_stream_data, 64'h0A0B0C0D0E0F1011);
      rx_q.push_back(64'h123456789ABCDEF0);
      rx_beat(32'h12345678, 1'b0);
      rx_beat(32'h9ABCDEF0, 1'b1);
      rx_idle();
      repeat (3) @(negedge clk);
      chk("after_early_good", 64'(end_cnt - ends0), 64'd1);

      // RX missing tlast: 4 beats, tlast on the 4th
      ends0 = end_cnt; errs0 = err_cnt;
      rx_beat(32'h00000001, 1'b0);
      rx_beat(32'h00000002, 1'b0);
      rx_beat(32'h00000003, 1'b0);
      rx_beat(32'h00000004, 1'b1);
      rx_idle();
      repeat (3) @(negedge clk);
      chk("drop_err_count", 64'(err_cnt - errs0), 64'd1);
      chk("drop_no_end", 64'(end_cnt - ends0), 64'd0);
      chk("drop_rx_idle", {62'h0, o_link_state[1:0]}, 64'h0);
      chk("drop_data_held", o_rx_stream_data, 64'h123456789ABCDEF0);

      // RX timeout after one beat
      errs0 = err_cnt;
      rx_beat(32'h55555555, 1'b0);
      rx_idle();
      repeat (10) @(negedge clk);
      chk("to_collecting", {62'h0, o_link_state[1:0]}, 64'h1);
      repeat (990) @(negedge clk);
      chk("to_not_yet", 64'(err_cnt - errs0), 64'd0);
      repeat (40) @(negedge clk);
      chk("to_err_count", 64'(err_cnt - errs0), 64'd1);
      chk("to_rx_idle", {62'h0, o_link_state[1:0]}, 64'h0);

      // Loopback
      loop = 1'b1;
      tx_q.push_back('{32'hCAFEF00D, 1'b0});
      tx_q.push_back('{32'h00000001, 1'b1});
      rx_q.push_back(64'hCAFEF00D00000001);
      send_start(64'hCAFEF00D00000001);
      @(negedge clk);
      chk("lb_end_t1", {63'h0, o_sfp_end_flag}, 64'h0);
      @(negedge clk);
      chk("lb_end_t2", {63'h0, o_sfp_end_flag}, 64'h0);
      @(negedge clk);
      chk("lb_end_t3", {63'h0, o_sfp_end_flag}, 64'h1);
      chk("lb_data", o_rx_stream_data, 64'hCAFEF00D00000001);

      // Reset in the middle of a loopback frame
      repeat (3) @(negedge clk);
      ends0 = end_cnt; errs0 = err_cnt;
      send_start(64'h0123456789ABCDEF);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_tx_outputs", {61'h0, m_axis_tvalid, m_axis_tlast, o_tx_busy}, 64'h0);
      chk("rst_rx_outputs", {61'h0, s_axis_tready, o_sfp_end_flag, o_rx_err}, 64'h0);
      chk("rst_link_state", {60'h0, o_link_state}, 64'h0);
      chk("rst_rx_data", o_rx_stream_data, 64'h0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_no_end", 64'(end_cnt - ends0), 64'd0);
      chk("rst_no_err", 64'(err_cnt - errs0), 64'd0);
      chk("rst_tx_quiet", {63'h0, m_axis_tvalid}, 64'h0);

      chk("tx_queue_drained", 64'(tx_q.size()), 64'd0);
      chk("rx_queue_drained", 64'(rx_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
